// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit combinational full-adder slice used by the serial adder datapath.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {carry_out, sum} = a + b + carry_in, LSB first, one bit per clock.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port that computes a - b (carry_out=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_s;
    logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the forced carry replaces carry_in.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : carry_in;
`else
    assign b_load     = b;
    assign carry_load = carry_in;
`endif

    fa_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                // Public result only changes on the DONE entry edge.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = sum_sh_d;
                    cout_d  = fa_cout;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand and partial-sum shifters are pure datapath and are reloaded on every start.
    always_ff @(posedge clk) begin
        a_sh_q   <= a_sh_d;
        b_sh_q   <= b_sh_d;
        sum_sh_q <= sum_sh_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule
